// File: rtl/load_unit_if.sv
// Load request, memory read and writeback signals of the load unit.
// slave: seen by load_unit; master: seen by the requester/memory model.
interface load_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] daddr;
    logic [4:0]  rd_in;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        fault;
    logic [1:0]  fault_cause;

    modport slave (
        input  start, funct3, daddr, rd_in, mem_rvalid, mem_rdata,
        output mem_re, mem_addr, busy, done, wb_data, wb_rd, fault, fault_cause
    );

    modport master (
        output start, funct3, daddr, rd_in, mem_rvalid, mem_rdata,
        input  mem_re, mem_addr, busy, done, wb_data, wb_rd, fault, fault_cause
    );
endinterface

// File: rtl/load_unit.sv
// RV32I load unit: validates a request, issues one word read, formats the byte/half/word.
// Latency 3 cycles start->done at zero wait; start is ignored while busy (no queueing).
module load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    load_unit_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [1:0] C_MISALIGN = 2'b01;
    localparam logic [1:0] C_ILLEGAL  = 2'b10;
    localparam logic [1:0] C_TIMEOUT  = 2'b11;

    logic [2:0]  state_q,   state_d;
    logic [2:0]  f3_q,      f3_d;
    logic [31:0] addr_q,    addr_d;
    logic [4:0]  rd_q,      rd_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [1:0]  cause_q,   cause_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q,   wb_rd_d;

    logic        f3_legal;
    logic        misaligned;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] fmt_data;

    always_comb begin
        f3_legal   = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                     (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                     (bus.funct3 == 3'b101);
        misaligned = ((bus.funct3[1:0] == 2'b01) && bus.daddr[0]) ||
                     ((bus.funct3 == 3'b010) && (bus.daddr[1:0] != 2'b00));
    end

    // Little-endian lane select on the latched address; funct3[2] marks unsigned loads.
    always_comb begin
        sel_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        sel_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (f3_q[1:0])
            2'b00:   fmt_data = {{24{sel_byte[7] & ~f3_q[2]}}, sel_byte};
            2'b01:   fmt_data = {{16{sel_half[15] & ~f3_q[2]}}, sel_half};
            default: fmt_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    f3_d   = bus.funct3;
                    addr_d = bus.daddr;
                    rd_d   = bus.rd_in;
                    if (!f3_legal) begin
                        cause_d = C_ILLEGAL;
                        state_d = S_FAULT;
                    end else if (misaligned) begin
                        cause_d = C_MISALIGN;
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    wb_data_d = fmt_data;
                    wb_rd_d   = rd_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        cause_d = C_TIMEOUT;
                        state_d = S_FAULT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            f3_q      <= 3'd0;
            addr_q    <= 32'd0;
            rd_q      <= 5'd0;
            cnt_q     <= 8'd0;
            cause_q   <= 2'd0;
            wb_data_q <= 32'd0;
            wb_rd_q   <= 5'd0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

    assign bus.mem_re      = (state_q == S_REQ);
    assign bus.mem_addr    = (state_q == S_REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.fault       = (state_q == S_FAULT);
    assign bus.fault_cause = (state_q == S_FAULT) ? cause_q : 2'b00;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_rd       = wb_rd_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with TIMEOUT=4; one check per observed value.
module tb_load_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    load_unit_if bus ();

    load_unit #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full successful load from IDLE: nwait empty WAIT cycles precede mem_rvalid.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] data, input int nwait,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
        bus.start = 1'b1; bus.funct3 = f3; bus.daddr = addr; bus.rd_in = rd;
        tick();
        bus.start = 1'b0;
        chk({tag, ".mem_re"}, 32'(bus.mem_re), 32'd1);
        chk({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        tick();
        repeat (nwait) begin
            chk({tag, ".no_done_wait"}, 32'(bus.done), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = data;
        tick();
        bus.mem_rvalid = 1'b0;
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".wb_data"}, bus.wb_data, exp_data);
        chk({tag, ".wb_rd"}, 32'(bus.wb_rd), 32'(rd));
        tick();
        chk({tag, ".done_low"}, 32'(bus.done), 32'd0);
        chk({tag, ".busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.funct3 = 3'd0; bus.daddr = 32'd0; bus.rd_in = 5'd0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        tick();
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.cause", 32'(bus.fault_cause), 32'd0);
        chk("rst.wb_data", bus.wb_data, 32'd0);
        chk("rst.wb_rd", 32'(bus.wb_rd), 32'd0);
        reset = 1'b1;
        tick();

        run_load("lb",  3'b000, 32'h103, 5'd5,  32'h80FF1234, 0, 32'h100, 32'hFFFFFF80);
        run_load("lhu", 3'b101, 32'h102, 5'd6,  32'h80FF1234, 0, 32'h100, 32'h000080FF);
        run_load("lh",  3'b001, 32'h102, 5'd7,  32'h80FF1234, 1, 32'h100, 32'hFFFF80FF);
        run_load("lw",  3'b010, 32'h100, 5'd8,  32'h80FF1234, 2, 32'h100, 32'h80FF1234);
        run_load("lbu", 3'b100, 32'h201, 5'd9,  32'h11A2B3C4, 0, 32'h200, 32'h000000B3);
        // mem_rvalid on the 4th WAIT cycle coincides with the timeout and wins
        run_load("edge", 3'b000, 32'h300, 5'd10, 32'h0000007F, 3, 32'h300, 32'h0000007F);

        // Misaligned LW: fault in cycle 1, no read issued, writeback untouched
        bus.start = 1'b1; bus.funct3 = 3'b010; bus.daddr = 32'h101; bus.rd_in = 5'd11;
        tick();
        bus.start = 1'b0;
        chk("mis.fault", 32'(bus.fault), 32'd1);
        chk("mis.cause", 32'(bus.fault_cause), 32'd1);
        chk("mis.mem_re", 32'(bus.mem_re), 32'd0);
        tick();
        chk("mis.fault_low", 32'(bus.fault), 32'd0);
        chk("mis.cause_low", 32'(bus.fault_cause), 32'd0);
        chk("mis.mem_re2", 32'(bus.mem_re), 32'd0);
        chk("mis.wb_data", bus.wb_data, 32'h0000007F);
        chk("mis.wb_rd", 32'(bus.wb_rd), 32'd10);

        // Illegal funct3 on a misaligned address: illegal takes priority
        bus.start = 1'b1; bus.funct3 = 3'b011; bus.daddr = 32'h101; bus.rd_in = 5'd12;
        tick();
        bus.start = 1'b0;
        chk("ill.fault", 32'(bus.fault), 32'd1);
        chk("ill.cause", 32'(bus.fault_cause), 32'd2);
        chk("ill.mem_re", 32'(bus.mem_re), 32'd0);
        tick();

        // Misaligned LHU
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.daddr = 32'h103;
        tick();
        bus.start = 1'b0;
        chk("mish.cause", 32'(bus.fault_cause), 32'd1);
        tick();

        // Timeout: 4 empty WAIT cycles (2..5), fault in cycle 6, late rvalid ignored
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.daddr = 32'h200; bus.rd_in = 5'd13;
        tick();
        bus.start = 1'b0;
        chk("to.mem_re", 32'(bus.mem_re), 32'd1);
        repeat (4) tick();
        chk("to.busy5", 32'(bus.busy), 32'd1);
        chk("to.nofault5", 32'(bus.fault), 32'd0);
        tick();
        chk("to.fault", 32'(bus.fault), 32'd1);
        chk("to.cause", 32'(bus.fault_cause), 32'd3);
        chk("to.wb_data", bus.wb_data, 32'h0000007F);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        chk("to.idle", 32'(bus.busy), 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        chk("to.late_done", 32'(bus.done), 32'd0);
        chk("to.late_wb", bus.wb_data, 32'h0000007F);

        // Busy handling: start in REQ ignored, start in the cycle busy falls accepted
        bus.start = 1'b1; bus.funct3 = 3'b010; bus.daddr = 32'h100; bus.rd_in = 5'd14;
        tick();
        bus.funct3 = 3'b011;
        tick();
        bus.start = 1'b0;
        chk("bb.nofault", 32'(bus.fault), 32'd0);
        chk("bb.wait_busy", 32'(bus.busy), 32'd1);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11223344;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("bb.done1", 32'(bus.done), 32'd1);
        chk("bb.wb1", bus.wb_data, 32'h11223344);
        tick();
        chk("bb.busy_low", 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.daddr = 32'h101; bus.rd_in = 5'd15;
        tick();
        bus.start = 1'b0;
        chk("bb.accept", 32'(bus.mem_re), 32'd1);
        tick();
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("bb.done2", 32'(bus.done), 32'd1);
        chk("bb.wb2", bus.wb_data, 32'h00000033);
        chk("bb.rd2", 32'(bus.wb_rd), 32'd15);
        tick();

        // Reset asserted in WAIT aborts the load
        bus.start = 1'b1; bus.funct3 = 3'b010; bus.daddr = 32'h100; bus.rd_in = 5'd3;
        tick();
        bus.start = 1'b0;
        tick();
        chk("rm.in_wait", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rm.busy", 32'(bus.busy), 32'd0);
        chk("rm.wb_data", bus.wb_data, 32'd0);
        chk("rm.wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rm.fault", 32'(bus.fault), 32'd0);
        tick();
        reset = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("rm.no_done", 32'(bus.done), 32'd0);
        chk("rm.no_fault", 32'(bus.fault), 32'd0);
        tick();
        run_load("after", 3'b001, 32'h102, 5'd4, 32'h7FFF0000, 0, 32'h100, 32'h00007FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
